// File: rtl/types_pkg.sv
// Shared types for the CDB writeback path: queue entries, broadcast bundle,
// source encodings and the modular ROB-age helpers.
package types_pkg;

  localparam int PREG_W = 7;
  localparam int ROB_W  = 5;
  localparam int DATA_W = 32;
  localparam int PC_W   = 32;

  localparam logic [1:0] CDB_SRC_ALU = 2'd0;
  localparam logic [1:0] CDB_SRC_MEM = 2'd1;
  localparam logic [1:0] CDB_SRC_BR  = 2'd2;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] preg;
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] data;
    logic              mispredict;
    logic [PC_W-1:0]   target;
  } cdb_entry;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] preg;
    logic              we;
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] data;
    logic [1:0]        src;
    logic              mispredict;
    logic [PC_W-1:0]   target;
  } cdb_bcast;

  // Age is the distance from the ROB head, so the subtraction wraps naturally
  function automatic logic isYounger(input logic [ROB_W-1:0] entryRob,
                                     input logic [ROB_W-1:0] flushRob,
                                     input logic [ROB_W-1:0] headRob);
    logic [ROB_W-1:0] entryAge;
    logic [ROB_W-1:0] flushAge;
    entryAge = entryRob - headRob;
    flushAge = flushRob - headRob;
    return entryAge > flushAge;
  endfunction

  // Round-robin successor in the order ALU -> MEM -> BR -> ALU
  function automatic logic [1:0] nextSrc(input logic [1:0] src);
    case (src)
      CDB_SRC_ALU: return CDB_SRC_MEM;
      CDB_SRC_MEM: return CDB_SRC_BR;
      default:     return CDB_SRC_ALU;
    endcase
  endfunction

endpackage

// File: rtl/cdb_src_queue.sv
// Per-source collapsing result queue. Entries stay in push order; flushed
// entries and the popped head are squeezed out in the same edge.
module cdb_src_queue
  import types_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  cdb_entry         i_pushEntry,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [ROB_W-1:0] i_flushRob,
  input  logic [ROB_W-1:0] i_robHead,
  output cdb_entry         o_head,
  output logic [CNT_W-1:0] o_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  cdb_entry         r_slots [DEPTH];
  logic [CNT_W-1:0] r_count;

  cdb_entry         w_next [DEPTH];
  logic [CNT_W-1:0] w_fill;
  logic [DEPTH-1:0] w_keep;
  logic             w_pushKeep;
  logic             w_popPending;
  logic             w_headFound;

  // Entries that survive this cycle's flush; only these are visible to the arbiter
  always_comb begin
    w_keep = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_keep[i] = r_slots[i].valid &&
                  !(i_flush && isYounger(r_slots[i].rob, i_flushRob, i_robHead));
    end
  end

  assign w_pushKeep = i_push && !(i_flush && isYounger(i_pushEntry.rob, i_flushRob, i_robHead));

  // Oldest surviving entry is the head offered for grant
  always_comb begin
    o_head      = '0;
    w_headFound = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_keep[i] && !w_headFound) begin
        o_head      = r_slots[i];
        w_headFound = 1'b1;
      end
    end
  end

  // Collapse survivors toward slot 0, drop the popped head, append the push
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_next[i] = '0;
    end
    w_fill       = '0;
    w_popPending = i_pop;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_keep[i]) begin
        if (w_popPending) begin
          w_popPending = 1'b0;
        end else begin
          w_next[w_fill[IDX_W-1:0]] = r_slots[i];
          w_fill = w_fill + CNT_W'(1);
        end
      end
    end
    if (w_pushKeep && (w_fill < FULL)) begin
      w_next[w_fill[IDX_W-1:0]]       = i_pushEntry;
      w_next[w_fill[IDX_W-1:0]].valid = 1'b1;
      w_fill = w_fill + CNT_W'(1);
    end
  end

  // Queue storage and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_slots[i] <= '0;
      end
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_slots[i] <= w_next[i];
      end
      r_count <= w_fill;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cdb_arbiter.sv
// CDB writeback arbiter: three source queues, mispredict override,
// round-robin selection and the registered broadcast.
module cdb_arbiter
  import types_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_alu_valid,
  input  logic [PREG_W-1:0] i_alu_preg,
  input  logic [ROB_W-1:0]  i_alu_rob,
  input  logic [DATA_W-1:0] i_alu_data,
  output logic              o_alu_ready,
  input  logic              i_mem_valid,
  input  logic [PREG_W-1:0] i_mem_preg,
  input  logic [ROB_W-1:0]  i_mem_rob,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_mem_ready,
  input  logic              i_br_valid,
  input  logic [PREG_W-1:0] i_br_preg,
  input  logic [ROB_W-1:0]  i_br_rob,
  input  logic [DATA_W-1:0] i_br_data,
  output logic              o_br_ready,
  input  logic              i_br_mispredict,
  input  logic [PC_W-1:0]   i_br_target,
  input  logic              i_flush_valid,
  input  logic [ROB_W-1:0]  i_flush_rob,
  input  logic [ROB_W-1:0]  i_rob_head,
  output logic              o_cdb_valid,
  output logic [PREG_W-1:0] o_cdb_preg,
  output logic              o_cdb_we,
  output logic [ROB_W-1:0]  o_cdb_rob,
  output logic [DATA_W-1:0] o_cdb_data,
  output logic [1:0]        o_cdb_src,
  output logic              o_cdb_mispredict,
  output logic [PC_W-1:0]   o_cdb_target
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  cdb_entry         w_pushEntry [3];
  cdb_entry         w_head [3];
  logic [CNT_W-1:0] w_count [3];
  logic [2:0]       w_valid;
  logic [2:0]       w_ready;
  logic [2:0]       w_push;
  logic [2:0]       w_pop;
  logic             w_grantValid;
  logic [1:0]       w_grantSrc;
  logic             w_override;
  logic [1:0]       w_cand;
  cdb_entry         w_grantEntry;

  logic [1:0]       r_rrPtr;
  cdb_bcast         r_bcast;

  assign w_valid = {i_br_valid, i_mem_valid, i_alu_valid};

  // Package each FU's offered result as a queue entry; only BR carries a redirect
  always_comb begin
    w_pushEntry[0] = '{valid: 1'b1, preg: i_alu_preg, rob: i_alu_rob, data: i_alu_data,
                       mispredict: 1'b0, target: '0};
    w_pushEntry[1] = '{valid: 1'b1, preg: i_mem_preg, rob: i_mem_rob, data: i_mem_data,
                       mispredict: 1'b0, target: '0};
    w_pushEntry[2] = '{valid: 1'b1, preg: i_br_preg, rob: i_br_rob, data: i_br_data,
                       mispredict: i_br_mispredict, target: i_br_target};
  end

  for (genvar g = 0; g < 3; g++) begin : g_queue
    assign w_ready[g] = (w_count[g] < FULL);
    assign w_push[g]  = w_valid[g] && w_ready[g];

    cdb_src_queue #(.DEPTH(DEPTH)) u_queue (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_push[g]),
      .i_pushEntry (w_pushEntry[g]),
      .i_pop       (w_pop[g]),
      .i_flush     (i_flush_valid),
      .i_flushRob  (i_flush_rob),
      .i_robHead   (i_rob_head),
      .o_head      (w_head[g]),
      .o_count     (w_count[g])
    );
  end

  assign o_alu_ready = w_ready[0];
  assign o_mem_ready = w_ready[1];
  assign o_br_ready  = w_ready[2];

  // Mispredicted branch at the BR head jumps the line; otherwise round-robin from the pointer
  always_comb begin
    w_grantValid = 1'b0;
    w_grantSrc   = CDB_SRC_ALU;
    w_override   = 1'b0;
    w_cand       = r_rrPtr;
    if (w_head[CDB_SRC_BR].valid && w_head[CDB_SRC_BR].mispredict) begin
      w_grantValid = 1'b1;
      w_grantSrc   = CDB_SRC_BR;
      w_override   = 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!w_grantValid && w_head[w_cand].valid) begin
          w_grantValid = 1'b1;
          w_grantSrc   = w_cand;
        end
        w_cand = nextSrc(w_cand);
      end
    end
  end

  // Pop only the granted source and pick its head for broadcast
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_pop[i] = w_grantValid && (w_grantSrc == 2'(i));
    end
    w_grantEntry = w_head[w_grantSrc];
  end

  // Pointer advances past the winner, but an override leaves fairness untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrPtr <= CDB_SRC_ALU;
    end else if (w_grantValid && !w_override) begin
      r_rrPtr <= nextSrc(w_grantSrc);
    end
  end

  // Broadcast register: load on grant, otherwise drop valid/we and hold the payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcast <= '0;
    end else if (w_grantValid) begin
      r_bcast.valid      <= 1'b1;
      r_bcast.preg       <= w_grantEntry.preg;
      r_bcast.we         <= |w_grantEntry.preg;
      r_bcast.rob        <= w_grantEntry.rob;
      r_bcast.data       <= w_grantEntry.data;
      r_bcast.src        <= w_grantSrc;
      r_bcast.mispredict <= w_grantEntry.mispredict;
      r_bcast.target     <= w_grantEntry.mispredict ? w_grantEntry.target : '0;
    end else begin
      r_bcast.valid <= 1'b0;
      r_bcast.we    <= 1'b0;
    end
  end

  assign o_cdb_valid      = r_bcast.valid;
  assign o_cdb_preg       = r_bcast.preg;
  assign o_cdb_we         = r_bcast.we;
  assign o_cdb_rob        = r_bcast.rob;
  assign o_cdb_data       = r_bcast.data;
  assign o_cdb_src        = r_bcast.src;
  assign o_cdb_mispredict = r_bcast.mispredict;
  assign o_cdb_target     = r_bcast.target;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-level model.
module tb_cdb_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_alu_valid = 1'b0, i_mem_valid = 1'b0, i_br_valid = 1'b0;
  logic [6:0]  i_alu_preg = '0, i_mem_preg = '0, i_br_preg = '0;
  logic [4:0]  i_alu_rob = '0, i_mem_rob = '0, i_br_rob = '0;
  logic [31:0] i_alu_data = '0, i_mem_data = '0, i_br_data = '0;
  logic        i_br_mispredict = 1'b0;
  logic [31:0] i_br_target = '0;
  logic        i_flush_valid = 1'b0;
  logic [4:0]  i_flush_rob = '0, i_rob_head = '0;
  logic        o_alu_ready, o_mem_ready, o_br_ready;
  logic        o_cdb_valid, o_cdb_we, o_cdb_mispredict;
  logic [6:0]  o_cdb_preg;
  logic [4:0]  o_cdb_rob;
  logic [31:0] o_cdb_data, o_cdb_target;
  logic [1:0]  o_cdb_src;

  int nChecks = 0;
  int nFails  = 0;
  bit cmpOn   = 1'b0;

  always #5 clk = ~clk;

  cdb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_alu_valid(i_alu_valid), .i_alu_preg(i_alu_preg), .i_alu_rob(i_alu_rob),
    .i_alu_data(i_alu_data), .o_alu_ready(o_alu_ready),
    .i_mem_valid(i_mem_valid), .i_mem_preg(i_mem_preg), .i_mem_rob(i_mem_rob),
    .i_mem_data(i_mem_data), .o_mem_ready(o_mem_ready),
    .i_br_valid(i_br_valid), .i_br_preg(i_br_preg), .i_br_rob(i_br_rob),
    .i_br_data(i_br_data), .o_br_ready(o_br_ready),
    .i_br_mispredict(i_br_mispredict), .i_br_target(i_br_target),
    .i_flush_valid(i_flush_valid), .i_flush_rob(i_flush_rob), .i_rob_head(i_rob_head),
    .o_cdb_valid(o_cdb_valid), .o_cdb_preg(o_cdb_preg), .o_cdb_we(o_cdb_we),
    .o_cdb_rob(o_cdb_rob), .o_cdb_data(o_cdb_data), .o_cdb_src(o_cdb_src),
    .o_cdb_mispredict(o_cdb_mispredict), .o_cdb_target(o_cdb_target)
  );

  // Reference model: plain arrays of pending results per source plus the expected bus
  typedef struct packed {
    logic [6:0]  preg;
    logic [4:0]  rob;
    logic [31:0] data;
    logic        misp;
    logic [31:0] target;
  } mEntry_t;

  mEntry_t     mQ [3][DEPTH];
  int          mCnt [3] = '{0, 0, 0};
  int          mPtr = 0;
  logic        eValid = 1'b0, eWe = 1'b0, eMisp = 1'b0;
  logic [6:0]  ePreg = '0;
  logic [4:0]  eRob = '0;
  logic [31:0] eData = '0, eTarget = '0;
  logic [1:0]  eSrc = '0;

  function automatic bit younger(input int x, input int f, input int h);
    return ((x - h + 32) % 32) > ((f - h + 32) % 32);
  endfunction

  function automatic bit inValid(input int s);
    case (s)
      0:       return i_alu_valid;
      1:       return i_mem_valid;
      default: return i_br_valid;
    endcase
  endfunction

  function automatic mEntry_t inEntry(input int s);
    mEntry_t e;
    case (s)
      0:       e = '{preg: i_alu_preg, rob: i_alu_rob, data: i_alu_data, misp: 1'b0, target: 32'h0};
      1:       e = '{preg: i_mem_preg, rob: i_mem_rob, data: i_mem_data, misp: 1'b0, target: 32'h0};
      default: e = '{preg: i_br_preg, rob: i_br_rob, data: i_br_data, misp: i_br_mispredict,
                     target: i_br_target};
    endcase
    return e;
  endfunction

  task automatic modelReset();
    for (int q = 0; q < 3; q++) mCnt[q] = 0;
    mPtr = 0;
    eValid = 1'b0; eWe = 1'b0; eMisp = 1'b0;
    ePreg = '0; eRob = '0; eData = '0; eTarget = '0; eSrc = '0;
  endtask

  task automatic modelStep();
    bit      rdy [3];
    int      g;
    int      n;
    int      s;
    mEntry_t e;
    for (int q = 0; q < 3; q++) rdy[q] = (mCnt[q] < DEPTH);
    if (i_flush_valid) begin
      for (int q = 0; q < 3; q++) begin
        n = 0;
        for (int j = 0; j < mCnt[q]; j++) begin
          if (!younger(int'(mQ[q][j].rob), int'(i_flush_rob), int'(i_rob_head))) begin
            mQ[q][n] = mQ[q][j];
            n++;
          end
        end
        mCnt[q] = n;
      end
    end
    g = -1;
    if (mCnt[2] > 0 && mQ[2][0].misp) begin
      g = 2;
    end else begin
      for (int k = 0; k < 3; k++) begin
        s = (mPtr + k) % 3;
        if (g < 0 && mCnt[s] > 0) g = s;
      end
      if (g >= 0) mPtr = (g + 1) % 3;
    end
    if (g >= 0) begin
      e = mQ[g][0];
      for (int j = 1; j < mCnt[g]; j++) mQ[g][j-1] = mQ[g][j];
      mCnt[g]--;
      eValid = 1'b1; ePreg = e.preg; eWe = (e.preg != 0); eRob = e.rob; eData = e.data;
      eSrc = 2'(g); eMisp = e.misp; eTarget = e.misp ? e.target : 32'h0;
    end else begin
      eValid = 1'b0;
      eWe = 1'b0;
    end
    for (int q = 0; q < 3; q++) begin
      e = inEntry(q);
      if (inValid(q) && rdy[q] &&
          !(i_flush_valid && younger(int'(e.rob), int'(i_flush_rob), int'(i_rob_head)))) begin
        mQ[q][mCnt[q]] = e;
        mCnt[q]++;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) modelReset();
    else modelStep();
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every cycle, the registered outputs must match the model
  always @(negedge clk) begin
    if (cmpOn) begin
      checkOutput("model alu_ready", 64'(o_alu_ready), 64'(mCnt[0] < DEPTH));
      checkOutput("model mem_ready", 64'(o_mem_ready), 64'(mCnt[1] < DEPTH));
      checkOutput("model br_ready", 64'(o_br_ready), 64'(mCnt[2] < DEPTH));
      checkOutput("model cdb_valid", 64'(o_cdb_valid), 64'(eValid));
      checkOutput("model cdb_we", 64'(o_cdb_we), 64'(eWe));
      checkOutput("model cdb_preg", 64'(o_cdb_preg), 64'(ePreg));
      checkOutput("model cdb_rob", 64'(o_cdb_rob), 64'(eRob));
      checkOutput("model cdb_data", 64'(o_cdb_data), 64'(eData));
      checkOutput("model cdb_src", 64'(o_cdb_src), 64'(eSrc));
      checkOutput("model cdb_mispredict", 64'(o_cdb_mispredict), 64'(eMisp));
      checkOutput("model cdb_target", 64'(o_cdb_target), 64'(eTarget));
    end
  end

  task automatic pushAlu(input logic [6:0] preg, input logic [4:0] rob, input logic [31:0] data);
    i_alu_valid = 1'b1; i_alu_preg = preg; i_alu_rob = rob; i_alu_data = data;
  endtask

  task automatic pushMem(input logic [6:0] preg, input logic [4:0] rob, input logic [31:0] data);
    i_mem_valid = 1'b1; i_mem_preg = preg; i_mem_rob = rob; i_mem_data = data;
  endtask

  task automatic pushBr(input logic [6:0] preg, input logic [4:0] rob, input logic [31:0] data,
                        input logic misp, input logic [31:0] target);
    i_br_valid = 1'b1; i_br_preg = preg; i_br_rob = rob; i_br_data = data;
    i_br_mispredict = misp; i_br_target = target;
  endtask

  // One clock with the currently driven inputs; returns just after the falling edge
  task automatic applyStimulus();
    @(posedge clk);
    @(negedge clk);
    #1;
    i_alu_valid = 1'b0; i_mem_valid = 1'b0; i_br_valid = 1'b0;
    i_br_mispredict = 1'b0; i_flush_valid = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    cmpOn = 1'b1;

    $display("[TB] reset state");
    checkOutput("reset cdb_valid", 64'(o_cdb_valid), 64'h0);
    checkOutput("reset cdb_rob", 64'(o_cdb_rob), 64'h0);
    checkOutput("reset cdb_data", 64'(o_cdb_data), 64'h0);
    checkOutput("reset alu_ready", 64'(o_alu_ready), 64'h1);
    checkOutput("reset br_ready", 64'(o_br_ready), 64'h1);

    $display("[TB] ALU-only stream");
    for (int i = 0; i < 4; i++) begin
      pushAlu(7'(10 + i), 5'(1 + i), 32'hA000 + 32'(i));
      applyStimulus();
      if (i == 0) begin
        checkOutput("stream latency", 64'(o_cdb_valid), 64'h0);
      end else begin
        checkOutput("stream rob", 64'(o_cdb_rob), 64'(i));
        checkOutput("stream preg", 64'(o_cdb_preg), 64'(9 + i));
        checkOutput("stream src", 64'(o_cdb_src), 64'h0);
      end
    end
    applyStimulus();
    checkOutput("stream last rob", 64'(o_cdb_rob), 64'd4);
    checkOutput("stream last data", 64'(o_cdb_data), 64'hA003);
    checkOutput("stream last we", 64'(o_cdb_we), 64'h1);
    applyStimulus();
    checkOutput("stream idle", 64'(o_cdb_valid), 64'h0);

    $display("[TB] ALU queue fills");
    pushAlu(7'd20, 5'd8, 32'h20); pushMem(7'd21, 5'd9, 32'h21);
    applyStimulus();
    pushAlu(7'd22, 5'd10, 32'h22); pushMem(7'd23, 5'd11, 32'h23);
    applyStimulus();
    checkOutput("fill grant mem rob", 64'(o_cdb_rob), 64'd9);
    checkOutput("fill alu_ready", 64'(o_alu_ready), 64'h0);
    checkOutput("fill mem_ready", 64'(o_mem_ready), 64'h1);
    pushAlu(7'd24, 5'd12, 32'h24);
    applyStimulus();
    checkOutput("fill grant alu rob", 64'(o_cdb_rob), 64'd8);
    checkOutput("fill alu_ready again", 64'(o_alu_ready), 64'h1);
    applyStimulus();
    checkOutput("fill mem rob 11", 64'(o_cdb_rob), 64'd11);
    applyStimulus();
    checkOutput("fill alu rob 10", 64'(o_cdb_rob), 64'd10);
    applyStimulus();
    checkOutput("fill no capture when full", 64'(o_cdb_valid), 64'h0);

    $display("[TB] contention");
    doReset();
    pushAlu(7'd30, 5'd2, 32'h30); pushMem(7'd31, 5'd3, 32'h31);
    pushBr(7'd32, 5'd4, 32'h32, 1'b0, 32'h1234);
    applyStimulus();
    applyStimulus();
    checkOutput("contend 1 src", 64'(o_cdb_src), 64'd0);
    checkOutput("contend 1 rob", 64'(o_cdb_rob), 64'd2);
    applyStimulus();
    checkOutput("contend 2 src", 64'(o_cdb_src), 64'd1);
    checkOutput("contend 2 rob", 64'(o_cdb_rob), 64'd3);
    applyStimulus();
    checkOutput("contend 3 src", 64'(o_cdb_src), 64'd2);
    checkOutput("contend 3 rob", 64'(o_cdb_rob), 64'd4);
    checkOutput("contend 3 target", 64'(o_cdb_target), 64'h0);

    $display("[TB] mispredict override");
    pushAlu(7'd40, 5'd6, 32'h40); pushMem(7'd41, 5'd8, 32'h41);
    applyStimulus();
    pushAlu(7'd42, 5'd7, 32'h42); pushBr(7'd43, 5'd5, 32'h43, 1'b1, 32'h80);
    applyStimulus();
    checkOutput("override pre rob", 64'(o_cdb_rob), 64'd6);
    applyStimulus();
    checkOutput("override src", 64'(o_cdb_src), 64'd2);
    checkOutput("override rob", 64'(o_cdb_rob), 64'd5);
    checkOutput("override mispredict", 64'(o_cdb_mispredict), 64'h1);
    checkOutput("override target", 64'(o_cdb_target), 64'h80);
    applyStimulus();
    checkOutput("override then mem", 64'(o_cdb_rob), 64'd8);
    checkOutput("override then target", 64'(o_cdb_target), 64'h0);
    applyStimulus();
    checkOutput("override then alu", 64'(o_cdb_rob), 64'd7);

    $display("[TB] flush with wrap");
    doReset();
    i_rob_head = 5'd30;
    pushAlu(7'd50, 5'd31, 32'h50); pushMem(7'd51, 5'd0, 32'h51);
    pushBr(7'd52, 5'd2, 32'h52, 1'b0, 32'h0);
    applyStimulus();
    i_flush_valid = 1'b1; i_flush_rob = 5'd0;
    pushAlu(7'd53, 5'd1, 32'h53);
    applyStimulus();
    checkOutput("flush rob 31", 64'(o_cdb_rob), 64'd31);
    checkOutput("flush alu_ready", 64'(o_alu_ready), 64'h1);
    applyStimulus();
    checkOutput("flush rob 0", 64'(o_cdb_rob), 64'd0);
    checkOutput("flush rob 0 src", 64'(o_cdb_src), 64'd1);
    applyStimulus();
    checkOutput("flush drops rob 2 and 1", 64'(o_cdb_valid), 64'h0);
    i_rob_head = 5'd0;

    $display("[TB] x0 destination");
    pushAlu(7'd0, 5'd7, 32'hDEAD);
    applyStimulus();
    applyStimulus();
    checkOutput("x0 valid", 64'(o_cdb_valid), 64'h1);
    checkOutput("x0 we", 64'(o_cdb_we), 64'h0);
    checkOutput("x0 rob", 64'(o_cdb_rob), 64'd7);

    $display("[TB] async reset mid-stream");
    pushAlu(7'd60, 5'd3, 32'h60); pushMem(7'd61, 5'd4, 32'h61);
    pushBr(7'd62, 5'd5, 32'h62, 1'b0, 32'h0);
    applyStimulus();
    pushAlu(7'd63, 5'd6, 32'h63);
    applyStimulus();
    checkOutput("pre-reset valid", 64'(o_cdb_valid), 64'h1);
    checkOutput("pre-reset alu_ready", 64'(o_alu_ready), 64'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset valid", 64'(o_cdb_valid), 64'h0);
    checkOutput("async reset rob", 64'(o_cdb_rob), 64'h0);
    checkOutput("async reset data", 64'(o_cdb_data), 64'h0);
    checkOutput("async reset alu_ready", 64'(o_alu_ready), 64'h1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("no stale broadcast", 64'(o_cdb_valid), 64'h0);
    end

    $display("[TB] randomized traffic");
    for (int n = 0; n < 3000; n++) begin
      i_alu_valid = 1'($urandom_range(0, 1));
      i_alu_preg  = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom);
      i_alu_rob   = 5'($urandom);
      i_alu_data  = $urandom;
      i_mem_valid = 1'($urandom_range(0, 1));
      i_mem_preg  = 7'($urandom);
      i_mem_rob   = 5'($urandom);
      i_mem_data  = $urandom;
      i_br_valid  = 1'($urandom_range(0, 1));
      i_br_preg   = 7'($urandom);
      i_br_rob    = 5'($urandom);
      i_br_data   = $urandom;
      i_br_mispredict = ($urandom_range(0, 3) == 0);
      i_br_target     = $urandom;
      i_flush_valid   = ($urandom_range(0, 7) == 0);
      i_flush_rob     = 5'($urandom);
      if ($urandom_range(0, 15) == 0) i_rob_head = 5'($urandom);
      if (n == 1500) doReset();
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
